bus_arbiter_rr: RTL and testbench

Round-robin bus arbiter that shares the single snooping bus and the L2 port between the two cores. It sits between the per-core `req_core`/`flush_out` lines and the `grant_core1`/`grant_core2` inputs of the bus controller. It enforces one-hot grants, a turnaround gap between owners, flush priority on ties, and bounded ownership so that neither core starves the other.

---
 rtl/bus_arbiter_rr.sv | 177 +++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin owner selection for the shared snoop bus / L2 port.
// Two cores compete; grants are one-hot and registered. A dead gap of TURNAROUND
// cycles separates two owners. Flush requests win ties. An owner that has held the
// bus for MAX_HOLD cycles is forced off when the other core is waiting, but only
// once its own bus operation has gone idle.
module bus_arbiter_rr #(
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_core1,
    input  logic       req_core2,
    input  logic       flush_in1,
    input  logic       flush_in2,
    input  logic [1:0] bus_operation_in1,
    input  logic [1:0] bus_operation_in2,
    output logic       grant_core1,
    output logic       grant_core2,
    output logic [1:0] owner,
    output logic       preempt,
    output logic       arb_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT1 = 2'd1,
        ST_GRANT2 = 2'd2,
        ST_TURN   = 2'd3
    } state_t;

    // hold_cnt reaching HOLD_LIMIT at an edge means MAX_HOLD grant cycles are done
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);
    localparam logic [7:0] HOLD_SAT   = 8'(MAX_HOLD);
    localparam logic [3:0] TURN_LAST  = 4'(TURNAROUND - 1);

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;   // 0 = core 1, 1 = core 2
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] turn_cnt_q, turn_cnt_d;
    logic       preempted_q, preempted_d;     // current TURN follows a forced release
    logic       grant_core1_q, grant_core1_d;
    logic       grant_core2_q, grant_core2_d;
    logic [1:0] owner_q, owner_d;
    logic       preempt_q, preempt_d;
    logic       arb_busy_q, arb_busy_d;

    logic any_req;
    logic pick_core2;
    logic own_req;
    logic other_req;
    logic own_idle;

    // Winner selection used from IDLE and on the last TURN cycle
    always_comb begin
        any_req = req_core1 | req_core2;
        if (req_core1 && !req_core2) begin
            pick_core2 = 1'b0;
        end else if (!req_core1 && req_core2) begin
            pick_core2 = 1'b1;
        end else if (preempted_q) begin
            // the core just forced off must let the waiting core in first
            pick_core2 = ~last_grant_q;
        end else if (flush_in1 != flush_in2) begin
            pick_core2 = flush_in2;
        end else begin
            pick_core2 = ~last_grant_q;
        end
    end

    // View of the current owner's request, the other core's request and bus activity
    always_comb begin
        if (state_q == ST_GRANT2) begin
            own_req   = req_core2;
            other_req = req_core1;
            own_idle  = (bus_operation_in2 == 2'b00);
        end else begin
            own_req   = req_core1;
            other_req = req_core2;
            own_idle  = (bus_operation_in1 == 2'b00);
        end
    end

    // Next-state and next-output computation
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        hold_cnt_d   = hold_cnt_q;
        turn_cnt_d   = turn_cnt_q;
        preempted_d  = preempted_q;
        preempt_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d      = pick_core2 ? ST_GRANT2 : ST_GRANT1;
                    last_grant_d = pick_core2;
                    hold_cnt_d   = '0;
                    preempted_d  = 1'b0;
                end
            end
            ST_GRANT1, ST_GRANT2: begin
                if (!own_req) begin
                    // a voluntary release wins over a coincident preemption
                    state_d     = ST_TURN;
                    turn_cnt_d  = '0;
                    preempted_d = 1'b0;
                end else if ((hold_cnt_q >= HOLD_LIMIT) && other_req && own_idle) begin
                    state_d     = ST_TURN;
                    turn_cnt_d  = '0;
                    preempted_d = 1'b1;
                    preempt_d   = 1'b1;
                end else if (hold_cnt_q < HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            ST_TURN: begin
                if (turn_cnt_q == TURN_LAST) begin
                    turn_cnt_d  = '0;
                    preempted_d = 1'b0;
                    if (any_req) begin
                        state_d      = pick_core2 ? ST_GRANT2 : ST_GRANT1;
                        last_grant_d = pick_core2;
                        hold_cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        grant_core1_d = (state_d == ST_GRANT1);
        grant_core2_d = (state_d == ST_GRANT2);
        owner_d       = (state_d == ST_GRANT1) ? 2'd1 :
                        (state_d == ST_GRANT2) ? 2'd2 : 2'd0;
        arb_busy_d    = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset clears grants immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            hold_cnt_q    <= '0;
            turn_cnt_q    <= '0;
            preempted_q   <= 1'b0;
            grant_core1_q <= 1'b0;
            grant_core2_q <= 1'b0;
            owner_q       <= 2'd0;
            preempt_q     <= 1'b0;
            arb_busy_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            hold_cnt_q    <= hold_cnt_d;
            turn_cnt_q    <= turn_cnt_d;
            preempted_q   <= preempted_d;
            grant_core1_q <= grant_core1_d;
            grant_core2_q <= grant_core2_d;
            owner_q       <= owner_d;
            preempt_q     <= preempt_d;
            arb_busy_q    <= arb_busy_d;
        end
    end

    assign grant_core1 = grant_core1_q;
    assign grant_core2 = grant_core2_q;
    assign owner       = owner_q;
    assign preempt     = preempt_q;
    assign arb_busy    = arb_busy_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed scenarios on a MAX_HOLD=4/TURNAROUND=1 arbiter plus a
// random soak of that arbiter and a MAX_HOLD=5/TURNAROUND=3 one against a
// cycle-level ownership model.
module tb_bus_arbiter_rr;

    localparam int A_HOLD = 4;
    localparam int A_TURN = 1;
    localparam int B_HOLD = 5;
    localparam int B_TURN = 3;

    // packed observation: {grant1, grant2, owner[1:0], preempt, busy}
    localparam logic [5:0] OUT_IDLE = {1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    localparam logic [5:0] OUT_TURN = {1'b0, 1'b0, 2'd0, 1'b0, 1'b1};
    localparam logic [5:0] OUT_PRE  = {1'b0, 1'b0, 2'd0, 1'b1, 1'b1};
    localparam logic [5:0] OUT_G1   = {1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
    localparam logic [5:0] OUT_G2   = {1'b0, 1'b1, 2'd2, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_core1 = 1'b0;
    logic       req_core2 = 1'b0;
    logic       flush_in1 = 1'b0;
    logic       flush_in2 = 1'b0;
    logic [1:0] bus_operation_in1 = 2'b00;
    logic [1:0] bus_operation_in2 = 2'b00;

    logic       a_g1, a_g2, a_pre, a_busy;
    logic [1:0] a_owner;
    logic       b_g1, b_g2, b_pre, b_busy;
    logic [1:0] b_owner;
    logic [5:0] a_out, b_out;

    int total = 0;
    int bad   = 0;

    assign a_out = {a_g1, a_g2, a_owner, a_pre, a_busy};
    assign b_out = {b_g1, b_g2, b_owner, b_pre, b_busy};

    always #5 clk = ~clk;

    bus_arbiter_rr #(.MAX_HOLD(A_HOLD), .TURNAROUND(A_TURN)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_core1(req_core1), .req_core2(req_core2),
        .flush_in1(flush_in1), .flush_in2(flush_in2),
        .bus_operation_in1(bus_operation_in1), .bus_operation_in2(bus_operation_in2),
        .grant_core1(a_g1), .grant_core2(a_g2), .owner(a_owner),
        .preempt(a_pre), .arb_busy(a_busy)
    );

    bus_arbiter_rr #(.MAX_HOLD(B_HOLD), .TURNAROUND(B_TURN)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_core1(req_core1), .req_core2(req_core2),
        .flush_in1(flush_in1), .flush_in2(flush_in2),
        .bus_operation_in1(bus_operation_in1), .bus_operation_in2(bus_operation_in2),
        .grant_core1(b_g1), .grant_core2(b_g2), .owner(b_owner),
        .preempt(b_pre), .arb_busy(b_busy)
    );

    // ---------------- reference model ----------------
    // owner: 0 none, 1/2 core; cycles: grant cycles completed; gap: dead cycles left;
    // last: last core granted; forced: gap follows a preemption; pulse: preempt output
    typedef struct {
        int owner;
        int cycles;
        int gap;
        int last;
        bit forced;
        bit pulse;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    function automatic mdl_t mreset();
        mdl_t m;
        m.owner  = 0;
        m.cycles = 0;
        m.gap    = 0;
        m.last   = 2;
        m.forced = 1'b0;
        m.pulse  = 1'b0;
        return m;
    endfunction

    function automatic int choose(mdl_t m, logic r1, logic r2, logic f1, logic f2);
        int other;
        other = (m.last == 1) ? 2 : 1;
        if (!r1 && !r2) return 0;
        if (r1 && !r2)  return 1;
        if (r2 && !r1)  return 2;
        if (m.forced)   return other;
        if (f1 && !f2)  return 1;
        if (f2 && !f1)  return 2;
        return other;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int max_hold, int turnaround,
                                   logic r1, logic r2, logic f1, logic f2,
                                   logic [1:0] o1, logic [1:0] o2);
        mdl_t n;
        int   w;
        logic own_r, oth_r;
        logic [1:0] own_op;
        n = m;
        n.pulse = 1'b0;
        if (m.owner != 0) begin
            n.cycles = m.cycles + 1;
            own_r  = (m.owner == 1) ? r1 : r2;
            oth_r  = (m.owner == 1) ? r2 : r1;
            own_op = (m.owner == 1) ? o1 : o2;
            if (!own_r) begin
                n.owner = 0; n.gap = turnaround; n.forced = 1'b0;
            end else if (n.cycles >= max_hold && oth_r && own_op == 2'b00) begin
                n.owner = 0; n.gap = turnaround; n.forced = 1'b1; n.pulse = 1'b1;
            end
        end else if (m.gap > 1) begin
            n.gap = m.gap - 1;
        end else begin
            w = choose(m, r1, r2, f1, f2);
            n.gap = 0;
            n.forced = 1'b0;
            if (w != 0) begin
                n.owner = w; n.cycles = 0; n.last = w;
            end
        end
        return n;
    endfunction

    function automatic logic [5:0] mexp(mdl_t m);
        return {m.owner == 1, m.owner == 2, 2'(m.owner), m.pulse, (m.owner != 0) || (m.gap != 0)};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, A_HOLD, A_TURN, req_core1, req_core2, flush_in1, flush_in2,
                        bus_operation_in1, bus_operation_in2);
            mb <= mstep(mb, B_HOLD, B_TURN, req_core1, req_core2, flush_in1, flush_in2,
                        bus_operation_in1, bus_operation_in2);
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (a_out !== OUT_IDLE) begin bad++; $display("FAIL reset_a: out=%b want=%b", a_out, OUT_IDLE); end
        total++; if (b_out !== OUT_IDLE) begin bad++; $display("FAIL reset_b: out=%b want=%b", b_out, OUT_IDLE); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (a_out !== OUT_IDLE) begin bad++; $display("FAIL idle_after_reset: out=%b want=%b", a_out, OUT_IDLE); end
        req_core2 = 1'b1;
        @(negedge clk);
        total++; if (a_out !== OUT_G2) begin bad++; $display("FAIL single_req_a: out=%b want=%b", a_out, OUT_G2); end
        total++; if (b_out !== OUT_G2) begin bad++; $display("FAIL single_req_b: out=%b want=%b", b_out, OUT_G2); end
        $display("test_reset: single request core2 -> owner=%0d", a_owner);
        req_core2 = 1'b0;
        @(negedge clk);
        total++; if (a_out !== OUT_TURN) begin bad++; $display("FAIL release_turn: out=%b want=%b", a_out, OUT_TURN); end
        @(negedge clk);
        total++; if (a_out !== OUT_IDLE) begin bad++; $display("FAIL release_idle: out=%b want=%b", a_out, OUT_IDLE); end
    endtask

    task automatic test_tie_rr();
        req_core1 = 1'b1; req_core2 = 1'b1;
        @(negedge clk);
        total++; if (a_out !== OUT_G1) begin bad++; $display("FAIL tie_first: out=%b want=%b", a_out, OUT_G1); end
        req_core1 = 1'b0;
        @(negedge clk);
        total++; if (a_out !== OUT_TURN) begin bad++; $display("FAIL tie_gap: out=%b want=%b", a_out, OUT_TURN); end
        @(negedge clk);
        total++; if (a_out !== OUT_G2) begin bad++; $display("FAIL tie_second: out=%b want=%b", a_out, OUT_G2); end
        req_core2 = 1'b0; req_core1 = 1'b1;
        @(negedge clk);
        total++; if (a_out !== OUT_TURN) begin bad++; $display("FAIL tie_gap2: out=%b want=%b", a_out, OUT_TURN); end
        req_core2 = 1'b1;
        @(negedge clk);
        total++; if (a_out !== OUT_G1) begin bad++; $display("FAIL tie_third: out=%b want=%b", a_out, OUT_G1); end
        $display("test_tie_rr: round-robin sequence core1, core2, core1 -> owner=%0d", a_owner);
        req_core1 = 1'b0; req_core2 = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (a_out !== OUT_IDLE) begin bad++; $display("FAIL tie_end_idle: out=%b want=%b", a_out, OUT_IDLE); end
    endtask

    task automatic test_flush();
        req_core2 = 1'b1;
        @(negedge clk);
        total++; if (a_out !== OUT_G2) begin bad++; $display("FAIL flush_setup: out=%b want=%b", a_out, OUT_G2); end
        req_core2 = 1'b0;
        repeat (2) @(negedge clk);
        req_core1 = 1'b1; req_core2 = 1'b1; flush_in2 = 1'b1;
        @(negedge clk);
        total++; if (a_out !== OUT_G2) begin bad++; $display("FAIL flush2_wins: out=%b want=%b", a_out, OUT_G2); end
        $display("test_flush: flush2 tie with last=core2 -> owner=%0d", a_owner);
        req_core1 = 1'b0; req_core2 = 1'b0; flush_in2 = 1'b0;
        repeat (2) @(negedge clk);
        req_core1 = 1'b1; req_core2 = 1'b1; flush_in1 = 1'b1; flush_in2 = 1'b1;
        @(negedge clk);
        total++; if (a_out !== OUT_G1) begin bad++; $display("FAIL flush_both_rr: out=%b want=%b", a_out, OUT_G1); end
        req_core1 = 1'b0; req_core2 = 1'b0; flush_in2 = 1'b0;
        repeat (2) @(negedge clk);
        req_core1 = 1'b1; req_core2 = 1'b1;
        @(negedge clk);
        total++; if (a_out !== OUT_G1) begin bad++; $display("FAIL flush1_wins: out=%b want=%b", a_out, OUT_G1); end
        $display("test_flush: flush1 tie with last=core1 -> owner=%0d", a_owner);
        req_core1 = 1'b0; req_core2 = 1'b0; flush_in1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_preempt();
        // last grant is core 1 here; core 1 also flags a flush, which must not
        // let it win straight back after being preempted
        req_core1 = 1'b1; flush_in1 = 1'b1;
        @(negedge clk);
        total++; if (a_out !== OUT_G1) begin bad++; $display("FAIL pre_start: out=%b want=%b", a_out, OUT_G1); end
        req_core2 = 1'b1;
        for (int i = 0; i < A_HOLD - 1; i++) begin
            @(negedge clk);
            total++; if (a_out !== OUT_G1) begin bad++; $display("FAIL pre_hold1 cyc%0d: out=%b want=%b", i, a_out, OUT_G1); end
        end
        @(negedge clk);
        total++; if (a_out !== OUT_PRE) begin bad++; $display("FAIL pre_pulse1: out=%b want=%b", a_out, OUT_PRE); end
        @(negedge clk);
        total++; if (a_out !== OUT_G2) begin bad++; $display("FAIL pre_handover1: out=%b want=%b", a_out, OUT_G2); end
        $display("test_preempt: core1 preempted -> owner=%0d", a_owner);
        flush_in1 = 1'b0;
        for (int i = 0; i < A_HOLD - 1; i++) begin
            @(negedge clk);
            total++; if (a_out !== OUT_G2) begin bad++; $display("FAIL pre_hold2 cyc%0d: out=%b want=%b", i, a_out, OUT_G2); end
        end
        @(negedge clk);
        total++; if (a_out !== OUT_PRE) begin bad++; $display("FAIL pre_pulse2: out=%b want=%b", a_out, OUT_PRE); end
        @(negedge clk);
        total++; if (a_out !== OUT_G1) begin bad++; $display("FAIL pre_handover2: out=%b want=%b", a_out, OUT_G1); end
        $display("test_preempt: core2 preempted -> owner=%0d", a_owner);
        req_core1 = 1'b0; req_core2 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_preempt_deferred();
        req_core1 = 1'b1; bus_operation_in1 = 2'b01;
        @(negedge clk);
        total++; if (a_out !== OUT_G1) begin bad++; $display("FAIL def_start: out=%b want=%b", a_out, OUT_G1); end
        req_core2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++; if (a_out !== OUT_G1) begin bad++; $display("FAIL def_hold cyc%0d: out=%b want=%b", i, a_out, OUT_G1); end
        end
        bus_operation_in1 = 2'b00;
        @(negedge clk);
        total++; if (a_out !== OUT_PRE) begin bad++; $display("FAIL def_pulse: out=%b want=%b", a_out, OUT_PRE); end
        @(negedge clk);
        total++; if (a_out !== OUT_G2) begin bad++; $display("FAIL def_handover: out=%b want=%b", a_out, OUT_G2); end
        $display("test_preempt_deferred: release after bus op idle -> owner=%0d", a_owner);
        req_core1 = 1'b0; req_core2 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        // owner drops req on the very edge the preempt condition is met
        req_core1 = 1'b1;
        @(negedge clk);
        req_core2 = 1'b1;
        repeat (A_HOLD - 1) @(negedge clk);
        total++; if (a_out !== OUT_G1) begin bad++; $display("FAIL sim_hold: out=%b want=%b", a_out, OUT_G1); end
        req_core1 = 1'b0;
        @(negedge clk);
        total++; if (a_out !== OUT_TURN) begin bad++; $display("FAIL sim_no_preempt: out=%b want=%b", a_out, OUT_TURN); end
        @(negedge clk);
        total++; if (a_out !== OUT_G2) begin bad++; $display("FAIL sim_next: out=%b want=%b", a_out, OUT_G2); end
        $display("test_simultaneous: voluntary release wins -> owner=%0d", a_owner);
        req_core2 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset();
        req_core2 = 1'b1;
        @(negedge clk);
        total++; if (a_out !== OUT_G2) begin bad++; $display("FAIL ar_grant: out=%b want=%b", a_out, OUT_G2); end
        #2 reset = 1'b0;
        #1;
        total++; if (a_out !== OUT_IDLE) begin bad++; $display("FAIL ar_drop_a: out=%b want=%b", a_out, OUT_IDLE); end
        total++; if (b_out !== OUT_IDLE) begin bad++; $display("FAIL ar_drop_b: out=%b want=%b", b_out, OUT_IDLE); end
        @(negedge clk);
        total++; if (a_out !== OUT_IDLE) begin bad++; $display("FAIL ar_held: out=%b want=%b", a_out, OUT_IDLE); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (a_out !== OUT_G2) begin bad++; $display("FAIL ar_regrant_a: out=%b want=%b", a_out, OUT_G2); end
        total++; if (b_out !== OUT_G2) begin bad++; $display("FAIL ar_regrant_b: out=%b want=%b", b_out, OUT_G2); end
        $display("test_async_reset: grant cleared and re-granted -> owner=%0d", a_owner);
        req_core2 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_soak();
        logic [5:0] ea;
        logic [5:0] eb;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            ea = mexp(ma);
            eb = mexp(mb);
            total++; if (a_out !== ea) begin bad++; $display("FAIL soak_a cyc%0d: out=%b want=%b", cyc, a_out, ea); end
            total++; if (b_out !== eb) begin bad++; $display("FAIL soak_b cyc%0d: out=%b want=%b", cyc, b_out, eb); end
            total++; if ((a_g1 && a_g2) || (a_owner !== {a_g2, a_g1})) begin bad++; $display("FAIL soak_inv_a cyc%0d: g1=%b g2=%b owner=%0d", cyc, a_g1, a_g2, a_owner); end
            total++; if ((b_g1 && b_g2) || (b_owner !== {b_g2, b_g1})) begin bad++; $display("FAIL soak_inv_b cyc%0d: g1=%b g2=%b owner=%0d", cyc, b_g1, b_g2, b_owner); end
            if (!reset) reset = 1'b1;
            if ($urandom_range(0, 7) == 0) req_core1 = ~req_core1;
            if ($urandom_range(0, 7) == 0) req_core2 = ~req_core2;
            flush_in1 = ($urandom_range(0, 3) == 0);
            flush_in2 = ($urandom_range(0, 3) == 0);
            bus_operation_in1 = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus_operation_in2 = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ((cyc % 2500) == 1234) #2 reset = 1'b0;
        end
        $display("test_soak: 10000 random cycles on both arbiters");
    endtask

    initial begin
        test_reset();
        test_tie_rr();
        test_flush();
        test_preempt();
        test_preempt_deferred();
        test_simultaneous();
        test_async_reset();
        test_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
